// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit write-only sequencer.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT, INIT, IDLE, SETUP_H, E_H, GAP, SETUP_L, E_L, EXEC
  } seq_state_e;

  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_HIGH} pulse_state_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;

  // Element [0] is sent first.
  localparam logic [3:0][3:0] INIT_NIBBLES = {4'h2, 4'h3, 4'h3, 4'h3};
  localparam logic [3:0][7:0] INIT_BYTES   = {CMD_CLEAR, CMD_DISP_ON, CMD_ENTRY, CMD_FUNC_SET};

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_e_pulser.sv
// Presents one nibble, waits the setup time, then drives a fixed-width E pulse.
// done is high for the single cycle whose closing edge drops lcd_e.
module lcd_e_pulser
  import lcd_pkg::*;
#(
  parameter int T_SETUP  = 4,
  parameter int T_E_HIGH = 24,
  parameter int PW       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       done
);

  pulse_state_e    state;
  logic [PW-1:0]   cnt;

  assign done = (state == P_HIGH) && (cnt == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= P_IDLE;
      cnt    <= '0;
      lcd_e  <= 1'b0;
      lcd_d  <= 4'h0;
      lcd_rs <= 1'b0;
    end else begin
      unique case (state)
        P_IDLE: begin
          if (start) begin
            lcd_d  <= nibble;
            lcd_rs <= rs;
            cnt    <= PW'(T_SETUP - 1);
            state  <= P_SETUP;
          end else if (clear) begin
            lcd_d  <= 4'h0;
            lcd_rs <= 1'b0;
          end
        end
        P_SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= PW'(T_E_HIGH - 1);
            state <= P_HIGH;
          end else begin
            cnt <= cnt - PW'(1);
          end
        end
        P_HIGH: begin
          // Pins stay put on the falling edge; only a later start or clear moves them.
          if (cnt == '0) begin
            lcd_e <= 1'b0;
            state <= P_IDLE;
          end else begin
            cnt <= cnt - PW'(1);
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_nibble_sequencer.sv
// HD44780 4-bit write-only controller: runs power-on init, then writes client
// bytes as two nibbles and waits out each byte's execution time.
module lcd_nibble_sequencer
  import lcd_pkg::*;
#(
  parameter int T_PWRUP      = 1500000,
  parameter int T_INIT_LONG  = 410000,
  parameter int T_INIT_SHORT = 10000,
  parameter int T_SETUP      = 4,
  parameter int T_E_HIGH     = 24,
  parameter int T_GAP        = 100,
  parameter int T_CMD        = 4000,
  parameter int T_CLR        = 164000,
  parameter int CW           = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d
);

  localparam int PW = $clog2(((T_SETUP > T_E_HIGH) ? T_SETUP : T_E_HIGH) + 1);

  seq_state_e    state;
  logic [CW-1:0] timer;
  logic [1:0]    init_idx;
  logic [1:0]    byte_idx;
  logic          nib_wait;
  logic [7:0]    byte_data;
  logic          byte_rs;

  logic          p_start, p_clear, p_rs, p_done;
  logic [3:0]    p_nib;
  logic          accept, timer_zero, more_init_bytes;

  assign accept          = req_valid && req_ready;
  assign timer_zero      = (timer == '0);
  assign more_init_bytes = !init_done && (byte_idx != 2'd3);
  assign lcd_rw          = 1'b0;

  function automatic logic [CW-1:0] init_wait(input logic [1:0] idx);
    case (idx)
      2'd0:    return CW'(T_INIT_LONG - 1);
      2'd1:    return CW'(T_INIT_SHORT - 1);
      default: return CW'(T_CMD - 1);
    endcase
  endfunction

  // The pulser is started on the very edge a wait expires, so its launch is combinational.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    p_start = 1'b0;
    p_clear = 1'b0;
    p_nib   = 4'h0;
    p_rs    = 1'b0;
    unique case (state)
      PWR_WAIT: if (timer_zero) begin
        p_start = 1'b1;
        p_nib   = INIT_NIBBLES[0];
      end
      INIT: if (nib_wait && timer_zero) begin
        p_start = 1'b1;
        p_nib   = (init_idx == 2'd3) ? INIT_BYTES[0][7:4] : INIT_NIBBLES[init_idx + 2'd1];
      end
      IDLE: if (accept) begin
        p_start = 1'b1;
        p_nib   = req_data[7:4];
        p_rs    = req_rs;
      end
      GAP: if (timer_zero) begin
        p_start = 1'b1;
        p_nib   = byte_data[3:0];
        p_rs    = byte_rs;
      end
      EXEC: if (timer_zero) begin
        if (more_init_bytes) begin
          p_start = 1'b1;
          p_nib   = INIT_BYTES[byte_idx + 2'd1][7:4];
        end else begin
          p_clear = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWR_WAIT;
      timer     <= CW'(T_PWRUP - 1);
      init_idx  <= 2'd0;
      byte_idx  <= 2'd0;
      nib_wait  <= 1'b0;
      byte_data <= 8'h00;
      byte_rs   <= 1'b0;
      init_done <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      unique case (state)
        PWR_WAIT: begin
          if (timer_zero) state <= INIT;
          else            timer <= timer - CW'(1);
        end
        INIT: begin
          if (!nib_wait) begin
            if (p_done) begin
              nib_wait <= 1'b1;
              timer    <= init_wait(init_idx);
            end
          end else if (!timer_zero) begin
            timer <= timer - CW'(1);
          end else if (init_idx != 2'd3) begin
            init_idx <= init_idx + 2'd1;
            nib_wait <= 1'b0;
          end else begin
            state     <= SETUP_H;
            byte_idx  <= 2'd0;
            byte_rs   <= 1'b0;
            byte_data <= INIT_BYTES[0];
          end
        end
        IDLE: if (accept) begin
          state     <= SETUP_H;
          byte_rs   <= req_rs;
          byte_data <= req_data;
          req_ready <= 1'b0;
        end
        SETUP_H, E_H: begin
          if (p_done) begin
            state <= GAP;
            timer <= CW'(T_GAP - 1);
          end else if (lcd_e) begin
            state <= E_H;
          end
        end
        GAP: begin
          if (timer_zero) state <= SETUP_L;
          else            timer <= timer - CW'(1);
        end
        SETUP_L, E_L: begin
          if (p_done) begin
            state <= EXEC;
            timer <= is_clear_home(byte_rs, byte_data) ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
          end else if (lcd_e) begin
            state <= E_L;
          end
        end
        EXEC: begin
          if (!timer_zero) begin
            timer <= timer - CW'(1);
          end else if (more_init_bytes) begin
            state     <= SETUP_H;
            byte_idx  <= byte_idx + 2'd1;
            byte_data <= INIT_BYTES[byte_idx + 2'd1];
          end else begin
            state     <= IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_e_pulser #(
    .T_SETUP  (T_SETUP),
    .T_E_HIGH (T_E_HIGH),
    .PW       (PW)
  ) u_pulser (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (p_start),
    .clear  (p_clear),
    .nibble (p_nib),
    .rs     (p_rs),
    .lcd_e  (lcd_e),
    .lcd_d  (lcd_d),
    .lcd_rs (lcd_rs),
    .done   (p_done)
  );

endmodule

// File: tb/tb_lcd_nibble_sequencer.sv
// Scoreboard bench for lcd_nibble_sequencer: expected nibbles and exec waits are
// queued from the stimulus and compared as E pulses and ready edges appear.
module tb_lcd_nibble_sequencer;

  localparam int T_PWRUP      = 20;
  localparam int T_INIT_LONG  = 10;
  localparam int T_INIT_SHORT = 5;
  localparam int T_SETUP      = 2;
  localparam int T_E_HIGH     = 3;
  localparam int T_GAP        = 4;
  localparam int T_CMD        = 8;
  localparam int T_CLR        = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;

  lcd_nibble_sequencer #(
    .T_PWRUP(T_PWRUP), .T_INIT_LONG(T_INIT_LONG), .T_INIT_SHORT(T_INIT_SHORT),
    .T_SETUP(T_SETUP), .T_E_HIGH(T_E_HIGH), .T_GAP(T_GAP),
    .T_CMD(T_CMD), .T_CLR(T_CLR), .CW(21)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_ready(req_ready), .init_done(init_done),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d)
  );

  always #5 clk = ~clk;

  // kind: 0 = init-only nibble, 1 = high nibble of a byte, 2 = low nibble
  typedef struct packed {
    logic       rs;
    logic [3:0] nib;
    logic [1:0] kind;
  } exp_t;

  exp_t exp_q[$];
  int   exp_exec[$];

  int   tests = 0, fails = 0;
  int   cyc = 0, accepts = 0, pulses = 0;
  int   acc_cyc = 0, rise_cyc = 0, fall_cyc = 0, exp_w = 0;
  bit   pending_accept = 1'b0, first_pending = 1'b0;
  logic prev_e = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
  logic [4:0] held = 5'h0;
  exp_t cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    exp_q.push_back('{rs: rs, nib: d[7:4], kind: 2'd1});
    exp_q.push_back('{rs: rs, nib: d[3:0], kind: 2'd2});
  endtask

  task automatic load_init();
    exp_q.delete();
    exp_exec.delete();
    pending_accept = 1'b0;
    first_pending  = 1'b1;
    exp_q.push_back('{rs: 1'b0, nib: 4'h3, kind: 2'd0});
    exp_q.push_back('{rs: 1'b0, nib: 4'h3, kind: 2'd0});
    exp_q.push_back('{rs: 1'b0, nib: 4'h3, kind: 2'd0});
    exp_q.push_back('{rs: 1'b0, nib: 4'h2, kind: 2'd0});
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  // Handshake monitor: edge count since reset release and scoreboard pushes on accept.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else begin
      cyc++;
      if (req_valid && req_ready) begin
        accepts++;
        acc_cyc = cyc;
        pending_accept = 1'b1;
        check("accept_after_init", init_done, 1);
        push_byte(req_rs, req_data);
        if (!req_rs && req_data[7:2] == 6'd0 && req_data[1:0] != 2'd0) exp_exec.push_back(T_CLR);
        else exp_exec.push_back(T_CMD);
      end
    end
  end

  // Pin monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e = 1'b0; prev_ready = 1'b0; prev_done = 1'b0;
    end else begin
      if (lcd_e && !prev_e) begin
        pulses++;
        rise_cyc = cyc;
        held = {lcd_rs, lcd_d};
        check("rw_low", lcd_rw, 0);
        if (first_pending) begin
          check("first_e_cycle", cyc, T_PWRUP + T_SETUP);
          first_pending = 1'b0;
        end
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else begin cur.rs = 1'bx; cur.nib = 4'hx; cur.kind = 2'd0; end
        check("nibble", {lcd_rs, lcd_d}, {cur.rs, cur.nib});
        if (cur.kind == 2'd2) check("gap_cycles", cyc - fall_cyc, T_GAP + T_SETUP);
        if (pending_accept && cur.kind == 2'd1) begin
          check("setup_cycles", cyc - acc_cyc, T_SETUP);
          pending_accept = 1'b0;
        end
      end else if (lcd_e) begin
        check("hold_while_e", {lcd_rs, lcd_d}, held);
      end
      if (!lcd_e && prev_e) begin
        check("e_high_width", cyc - rise_cyc, T_E_HIGH);
        check("hold_at_fall", {lcd_rs, lcd_d}, held);
        fall_cyc = cyc;
      end
      if (init_done && !prev_done) begin
        check("init_done_delay", cyc - fall_cyc, T_CLR);
        check("init_stream_left", exp_q.size(), 0);
      end
      if (req_ready && !prev_ready && prev_done) begin
        if (exp_exec.size() != 0) exp_w = exp_exec.pop_front();
        else exp_w = -1;
        check("exec_wait", cyc - fall_cyc, exp_w);
        check("idle_lcd_d", lcd_d, 0);
      end
      prev_e = lcd_e; prev_ready = req_ready; prev_done = init_done;
    end
  end

  task automatic wait_init(input string tag);
    for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
    check(tag, init_done, 1);
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 400 && !req_ready; i++) @(negedge clk);
    check(tag, req_ready, 1);
  endtask

  task automatic wait_accept(input int a0, input int n, input string tag);
    for (int i = 0; i < 400 && accepts < a0 + n; i++) @(negedge clk);
    check(tag, accepts - a0, n);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    int a0;
    @(negedge clk);
    a0 = accepts;
    req_valid = 1'b1; req_rs = rs; req_data = d;
    @(negedge clk);
    wait_accept(a0, 1, "accepted_once");
    req_valid = 1'b0;
    wait_ready("ready_back");
  endtask

  task automatic restart();
    repeat (3) @(negedge clk);
    load_init();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int a0, p0;
    logic [7:0] b2b [3];
    b2b[0] = 8'h48; b2b[1] = 8'h69; b2b[2] = 8'h21;

    // Reset state and power-on init
    repeat (3) @(negedge clk);
    check("reset_outputs", {lcd_e, lcd_rs, lcd_rw, lcd_d, req_ready, init_done}, 0);
    restart();
    wait_init("init_done_1");

    // Single data byte, then clear/home vs ordinary exec waits
    send(1'b1, 8'h41);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h04);
    send(1'b1, 8'h01);

    // Back-to-back requests with req_valid held high
    @(negedge clk);
    a0 = accepts; p0 = pulses;
    req_valid = 1'b1; req_rs = 1'b1; req_data = b2b[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wait_accept(a0, k + 1, "b2b_accept");
      if (k < 2) req_data = b2b[k + 1];
    end
    req_valid = 1'b0;
    wait_ready("b2b_ready");
    check("b2b_accepts", accepts - a0, 3);
    check("b2b_pulses", pulses - p0, 6);

    // req_valid held high through a full init
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    a0 = accepts;
    restart();
    wait_init("init_done_2");
    @(negedge clk);
    wait_accept(a0, 1, "held_valid_accept");
    req_valid = 1'b0;
    wait_ready("held_valid_ready");

    // Asynchronous reset while lcd_e is high
    @(negedge clk);
    a0 = accepts;
    req_valid = 1'b1; req_rs = 1'b0; req_data = 8'h0C;
    @(negedge clk);
    wait_accept(a0, 1, "pre_reset_accept");
    req_valid = 1'b0;
    for (int i = 0; i < 100 && !lcd_e; i++) begin
      @(posedge clk);
      #2;
    end
    check("e_high_before_reset", lcd_e, 1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_e", lcd_e, 0);
    check("reset_outputs_async", {lcd_rs, lcd_d, req_ready, init_done}, 0);
    restart();
    wait_init("init_done_3");
    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
